// File: rtl/dmem_ws.sv
// dmem_ws: byte-addressed data memory with sub-word access, wait states and Ready/Valid handshake
module dmem_ws #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 16,
  parameter int LATENCY      = 2,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [DEPTH-1:0] Address,
  input  logic [1:0]       Size,
  input  logic             Unsigned,
  input  logic [WIDTH-1:0] WD,
  output logic             Ready,
  output logic             Valid,
  output logic             Err,
  output logic [WIDTH-1:0] RD
);
  localparam int BYTES = WIDTH / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int WORDS = 2 ** (DEPTH - OFFW);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;
  stateT state, nextState;
  logic [3:0] cnt;
  logic [DEPTH-1:0] addrQ, addr;
  logic [1:0] sizeQ, size;
  logic unsQ, writeQ, isUns, isWrite;
  logic [WIDTH-1:0] wdQ, wd;
  logic [WIDTH-1:0] mem [WORDS];
  logic req, live, enterResp, bad, sign;
  logic [OFFW-1:0] off;
  logic [DEPTH-OFFW-1:0] idx;
  logic [4:0] nBytes;
  logic [WIDTH-1:0] lane, loadData, storeData;
  logic [BYTES-1:0] byteEn;
  assign req   = MemRead | MemWrite;
  assign Ready = state == IDLE;
  assign Valid = state == RESP;
  // With zero wait states the access happens on the accepting edge, so operands come straight from the ports.
  always_comb begin
    live    = state == IDLE;
    addr    = live ? Address : addrQ;
    size    = live ? Size : sizeQ;
    isUns   = live ? Unsigned : unsQ;
    isWrite = live ? MemWrite : writeQ;
    wd      = live ? WD : wdQ;
    off     = addr[OFFW-1:0];
    idx     = addr[DEPTH-1:OFFW];
    nBytes  = 5'd1 << size;
    bad     = ((5'(off) & (nBytes - 5'd1)) != 5'd0) || (nBytes > 5'(BYTES));
    lane    = mem[idx] >> {off, 3'b000};
    storeData = wd << {off, 3'b000};
    sign    = 1'b0;
    for (int i = 0; i < BYTES; i++) if (5'(i) == nBytes - 5'd1) sign = lane[8*i+7];
    for (int i = 0; i < BYTES; i++) begin
      loadData[8*i+:8] = 5'(i) < nBytes ? lane[8*i+:8] : {8{sign & ~isUns}};
      byteEn[i] = 5'(i) >= 5'(off) && 5'(i) < 5'(off) + nBytes;
    end
  end
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (req) nextState = LATENCY == 0 ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    enterResp = nextState == RESP && state != RESP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      Err   <= 1'b0;
      RD    <= '0;
    end else begin
      state <= nextState;
      Err   <= enterResp & bad;
      if (state == IDLE && req) begin
        addrQ  <= Address;
        sizeQ  <= Size;
        unsQ   <= Unsigned;
        wdQ    <= WD;
        writeQ <= MemWrite;
        cnt    <= 4'(LATENCY);
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      if (enterResp && (bad || !isWrite)) RD <= bad ? '0 : loadData;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RST != 0) for (int w = 0; w < WORDS; w++) mem[w] <= '0;
    end else if (enterResp && isWrite && !bad) begin
      for (int i = 0; i < BYTES; i++) if (byteEn[i]) mem[idx][8*i+:8] <= storeData[8*i+:8];
    end
  end
endmodule

// File: doc/dmem_ws.md
Name: dmem_ws

Overview:
- Parametrised successor to the single-cycle data memory: byte-addressed data memory for the MIPS datapath.
- Adds sub-word loads/stores with sign or zero extension, and a configurable wait-state latency with a Ready/Valid handshake.
- Adds misalignment detection.
- Sits in the MEM stage between the ALU address output and the write-back mux; the stall logic uses Ready.

Parameters:
WIDTH, 32, data word width in bits; multiple of 8, 32 or 64
DEPTH, 16, address width in bits (byte address); array holds 2^(DEPTH-log2(WIDTH/8)) words
LATENCY, 2, wait states between request acceptance and response, 0..15
CLEAR_ON_RST, 1, 1 = reset zeroes the whole array; 0 = contents preserved across reset

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
MemRead  input  1  load request
MemWrite  input  1  store request; wins over MemRead if both high
Address  input  DEPTH  byte address
Size  input  2  access size = 2^Size bytes (0 byte, 1 half, 2 word, 3 dword)
Unsigned  input  1  1 = zero-extend load, 0 = sign-extend
WD  input  WIDTH  store data; low 2^Size bytes used
Ready  output  1  block idle, request accepted this cycle
Valid  output  1  one-cycle response pulse (load data or store ack)
Err  output  1  qualifies Valid: misaligned or illegal size
RD  output  WIDTH  load data, extended

Behaviour:
- Reset (rst high at edge): FSM -> IDLE; Valid=0, Err=0, RD=0, Ready=1 in the following cycle.
  - Array zeroed if CLEAR_ON_RST=1.
  - Any in-flight request is discarded. A pending store never commits.
- FSM states: IDLE, WAIT, RESP.
  - Ready = (state==IDLE).
- IDLE: at an edge with MemRead|MemWrite high, latch Address/Size/Unsigned/WD/op and the write flag.
  - Go to WAIT with counter=LATENCY, or straight to RESP if LATENCY=0.
  - Inputs are ignored while not IDLE.
- WAIT: counter decrements each edge. On the edge where counter==1, go to RESP.
  - Total: LATENCY edges in WAIT.
- Transition into RESP (single edge): perform the access using the latched values.
  - Load: RD <= extended data.
  - Store: byte-lane write of the selected bytes only; other bytes unchanged. RD holds its previous value.
- RESP: Valid=1 for exactly one cycle; next edge goes to IDLE.
  - Request-to-Valid: LATENCY+1 cycles.
  - Back-to-back throughput: one request per LATENCY+2 cycles.
- Addressing:
  - word index = Address[DEPTH-1:log2(WIDTH/8)]
  - lane offset = Address[log2(WIDTH/8)-1:0]
  - Little-endian: byte offset 0 = WD[7:0].
  - Top of the address space wraps naturally. No out-of-range case exists.
- Extension: a load of N=2^Size bytes takes lanes offset..offset+N-1.
  - Unsigned=0 replicates bit 8N-1 into RD[WIDTH-1:8N].
  - Unsigned=1 zero-fills.
  - For a full-width load, Unsigned has no effect.
- Error: Err=1 with Valid when either of these holds:
  - Address mod 2^Size != 0;
  - 2^Size > WIDTH/8 (e.g. Size=3 with WIDTH=32).
  - On error: no array write, RD <= 0.
  - Err=0 whenever Valid=0.
- Simultaneous MemRead and MemWrite: treated as a store.
- Reset has priority over every other event, including a Valid cycle. A Valid pulse cut by reset does not appear.

Test Plan:
- Reset with CLEAR_ON_RST=1 -> Ready=1, Valid=0, RD=0. A word load from 0x0010 returns 0x00000000 with Valid 3 cycles after acceptance (LATENCY=2).
- Word store 0xDEADBEEF at 0x0008, then byte load 0x000B with Unsigned=0 -> RD=0xFFFFFFDE. Same load with Unsigned=1 -> RD=0x000000DE.
- Halfword store 0x1234 at 0x000A over 0xDEADBEEF -> word load 0x0008 returns 0x1234BEEF. Byte store 0x7F at 0x0009 -> 0x12347FEF.
- Misaligned: halfword load at 0x0003, word store at 0x0006, Size=3 with WIDTH=32 -> Valid+Err, RD=0, memory unchanged.
  - Check via a word read of 0x0004 after first storing a known value there.
- Handshake: hold MemRead high continuously -> Ready low for 3 cycles, Valid once every 4 cycles. Requests presented while Ready=0 produce no extra response. Repeat with LATENCY=0 -> Valid the cycle after acceptance, one request per 2 cycles.
- Reset mid-operation: accept a store of 0xCAFEF00D at 0x0000 with CLEAR_ON_RST=0 and pulse rst during WAIT -> no Valid. The later word load of 0x0000 returns the old contents, not 0xCAFEF00D.
